// File: rtl/complex_result_accumulator.sv
// Accumulates a programmable number of complex products from the multiplier's
// result handshake into a signed complex sum and presents it on a valid/ready port.
module complex_result_accumulator #(
  parameter int DATA_W  = 17,
  parameter int GUARD_W = 8,
  parameter int CNT_W   = 8,
  localparam int ACC_W  = DATA_W + GUARD_W
) (
  input  logic              clk,
  input  logic              sw_rst,
  input  logic              res_val,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_re,
  input  logic [DATA_W-1:0] res_im,
  input  logic [CNT_W-1:0]  frame_len,
  output logic              acc_val,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_re,
  output logic [ACC_W-1:0]  acc_im,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic              acc_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_re_q, acc_re_d;
  logic [ACC_W-1:0] acc_im_q, acc_im_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] prod_re_s, prod_im_s;
  logic [ACC_W-1:0] sum_re_s, sum_im_s;
  logic [CNT_W-1:0] cnt_inc_s, len_in_s;
  logic             res_xfer_s;

  // Signed overflow: operands agree in sign but the wrapped result does not.
  function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                   input logic [ACC_W-1:0] b,
                                   input logic [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  assign prod_re_s  = ACC_W'($signed(res_re));
  assign prod_im_s  = ACC_W'($signed(res_im));
  assign sum_re_s   = acc_re_q + prod_re_s;
  assign sum_im_s   = acc_im_q + prod_im_s;
  assign cnt_inc_s  = cnt_q + CNT_W'(1);
  assign len_in_s   = (frame_len == {CNT_W{1'b0}}) ? CNT_W'(1) : frame_len;
  assign res_xfer_s = res_val && res_ready;

  // Handshake flags decode the registered state only, so acc_ready never reaches res_ready.
  assign res_ready = (state_q != DONE);
  assign acc_val   = (state_q == DONE);
  assign acc_re    = acc_re_q;
  assign acc_im    = acc_im_q;
  assign acc_cnt   = cnt_q;
  assign acc_ovf   = ovf_q;

  always_comb begin
    state_d  = state_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (res_xfer_s) begin
          acc_re_d = prod_re_s;
          acc_im_d = prod_im_s;
          cnt_d    = CNT_W'(1);
          len_d    = len_in_s;
          ovf_d    = 1'b0;
          state_d  = (len_in_s == CNT_W'(1)) ? DONE : ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (res_xfer_s) begin
          acc_re_d = sum_re_s;
          acc_im_d = sum_im_s;
          cnt_d    = cnt_inc_s;
          ovf_d    = ovf_q | add_ovf(acc_re_q, prod_re_s, sum_re_s)
                           | add_ovf(acc_im_q, prod_im_s, sum_im_s);
          state_d  = (cnt_inc_s == len_q) ? DONE : ACCUM;
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        // The frame length stays latched; it is overwritten by the next frame's first product.
        if (acc_ready) begin
          acc_re_d = {ACC_W{1'b0}};
          acc_im_d = {ACC_W{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          ovf_d    = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        acc_re_d = {ACC_W{1'b0}};
        acc_im_d = {ACC_W{1'b0}};
        cnt_d    = {CNT_W{1'b0}};
        len_d    = {CNT_W{1'b0}};
        ovf_d    = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q  <= IDLE;
      acc_re_q <= {ACC_W{1'b0}};
      acc_im_q <= {ACC_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      len_q    <= {CNT_W{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_complex_result_accumulator.sv
// Self-checking bench: a wide (GUARD_W=8) and a narrow (GUARD_W=0) accumulator share
// stimulus; sums and overflow flags are predicted with plain integer arithmetic.
module tb_complex_result_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sw_rst, res_val, acc_ready;
  logic [16:0] res_re, res_im;
  logic [7:0]  frame_len;

  logic        res_ready, acc_val, acc_ovf;
  logic [24:0] acc_re, acc_im;
  logic [7:0]  acc_cnt;

  logic        n_res_ready, n_acc_val, n_acc_ovf;
  logic [16:0] n_acc_re, n_acc_im;
  logic [7:0]  n_acc_cnt;

  int checks  = 0;
  int errors  = 0;
  int accepts = 0;
  int q_re[$];
  int q_im[$];

  complex_result_accumulator #(.DATA_W(17), .GUARD_W(8), .CNT_W(8)) u_wide (
    .clk(clk), .sw_rst(sw_rst), .res_val(res_val), .res_ready(res_ready),
    .res_re(res_re), .res_im(res_im), .frame_len(frame_len),
    .acc_val(acc_val), .acc_ready(acc_ready), .acc_re(acc_re), .acc_im(acc_im),
    .acc_cnt(acc_cnt), .acc_ovf(acc_ovf)
  );

  complex_result_accumulator #(.DATA_W(17), .GUARD_W(0), .CNT_W(8)) u_narrow (
    .clk(clk), .sw_rst(sw_rst), .res_val(res_val), .res_ready(n_res_ready),
    .res_re(res_re), .res_im(res_im), .frame_len(frame_len),
    .acc_val(n_acc_val), .acc_ready(acc_ready), .acc_re(n_acc_re), .acc_im(n_acc_im),
    .acc_cnt(n_acc_cnt), .acc_ovf(n_acc_ovf)
  );

  // Scoreboard of accepted products on the wide instance.
  always @(posedge clk) begin
    if (!sw_rst && res_val && res_ready) accepts <= accepts + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  task automatic model_add(input longint acc_in, input bit ovf_in, input longint p, input int w,
                           output longint acc_out, output bit ovf_out);
    longint exact;
    longint hi;
    exact   = acc_in + p;
    hi      = (longint'(1) << (w - 1)) - 1;
    ovf_out = ovf_in || (exact > hi) || (exact < -hi - 1);
    acc_out = wrapw(exact, w);
  endtask

  task automatic fill_rand(input int n);
    q_re.delete();
    q_im.delete();
    for (int i = 0; i < n; i++) begin
      q_re.push_back(int'($urandom_range(0, 131071)) - 65536);
      q_im.push_back(int'($urandom_range(0, 131071)) - 65536);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic put(input int re, input int im, input int flen);
    res_val   = 1'b1;
    res_re    = 17'(re);
    res_im    = 17'(im);
    frame_len = 8'(flen);
    for (int k = 0; k < 20 && !res_ready; k++) @(negedge clk);
    if (!res_ready) chk("res_ready_timeout", 0, 1);
    @(negedge clk);
    res_val = 1'b0;
  endtask

  task automatic do_frame(input int flen, input int later_len, input int gap_max,
                          input int hold, input bit ack_early);
    int     n;
    int     acc0;
    longint wre, wim, nre, nim;
    bit     wovf, novf;
    n    = (flen == 0) ? 1 : flen;
    acc0 = accepts;
    wre = q_re[0]; wim = q_im[0]; nre = q_re[0]; nim = q_im[0];
    wovf = 1'b0; novf = 1'b0;
    for (int i = 1; i < n; i++) begin
      model_add(wre, wovf, q_re[i], 25, wre, wovf);
      model_add(wim, wovf, q_im[i], 25, wim, wovf);
      model_add(nre, novf, q_re[i], 17, nre, novf);
      model_add(nim, novf, q_im[i], 17, nim, novf);
    end
    acc_ready = ack_early;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      put(q_re[i], q_im[i], (i == 0) ? flen : later_len);
    end
    chk("sum_val", acc_val, 1);
    chk("sum_res_ready", res_ready, 0);
    chk("sum_re", $signed(acc_re), wre);
    chk("sum_im", $signed(acc_im), wim);
    chk("sum_cnt", acc_cnt, n);
    chk("sum_ovf", acc_ovf, wovf);
    chk("nsum_val", n_acc_val, 1);
    chk("nsum_re", $signed(n_acc_re), nre);
    chk("nsum_im", $signed(n_acc_im), nim);
    chk("nsum_ovf", n_acc_ovf, novf);
    chk("accepts", accepts - acc0, n);
    if (!ack_early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_val", acc_val, 1);
        chk("hold_res_ready", res_ready, 0);
        chk("hold_re", $signed(acc_re), wre);
        chk("hold_im", $signed(acc_im), wim);
        chk("hold_cnt", acc_cnt, n);
      end
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    chk("post_val", acc_val, 0);
    chk("post_res_ready", res_ready, 1);
    chk("post_re", $signed(acc_re), 0);
    chk("post_cnt", acc_cnt, 0);
    chk("post_ovf", acc_ovf, 0);
    chk("accepts_after", accepts - acc0, n);
  endtask

  initial begin
    sw_rst = 1'b1; res_val = 1'b0; acc_ready = 1'b0;
    res_re = 17'd0; res_im = 17'd0; frame_len = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_val", acc_val, 0);
    chk("rst_res_ready", res_ready, 1);
    chk("rst_re", $signed(acc_re), 0);
    chk("rst_cnt", acc_cnt, 0);
    chk("rst_ovf", acc_ovf, 0);
    sw_rst = 1'b0;
    @(negedge clk);

    // Basic frame, consumer always ready.
    q_re = '{5, -7, 100}; q_im = '{-2, 4, 1};
    do_frame(3, 3, 0, 0, 1'b1);

    // Backpressure on a single-product frame.
    q_re = '{-65536}; q_im = '{65535};
    do_frame(1, 1, 0, 5, 1'b0);

    // Zero length behaves as one.
    fill_rand(1);
    do_frame(0, 0, 0, 2, 1'b0);

    // Length change after the first product is ignored.
    fill_rand(4);
    do_frame(4, 2, 0, 0, 1'b0);

    // Narrow instance wraps and flags overflow; next frame clears it.
    q_re = '{65535, 65535}; q_im = '{0, 0};
    do_frame(2, 2, 0, 0, 1'b0);
    q_re = '{1}; q_im = '{1};
    do_frame(1, 1, 0, 0, 1'b0);

    // Gapped input.
    q_re = '{1, 1, 1, 1}; q_im = '{1, 1, 1, 1};
    do_frame(4, 4, 3, 0, 1'b0);

    // Reset mid-frame discards the partial sum.
    fill_rand(3);
    for (int i = 0; i < 3; i++) put(q_re[i], q_im[i], 5);
    sw_rst = 1'b1; res_val = 1'b1; acc_ready = 1'b1;
    repeat (2) @(negedge clk);
    sw_rst = 1'b0; res_val = 1'b0; acc_ready = 1'b0;
    chk("mrst_val", acc_val, 0);
    chk("mrst_res_ready", res_ready, 1);
    chk("mrst_re", $signed(acc_re), 0);
    chk("mrst_im", $signed(acc_im), 0);
    chk("mrst_ovf", acc_ovf, 0);
    chk("mrst_cnt", acc_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst_no_sum", acc_val, 0);
    end
    fill_rand(2);
    do_frame(2, 2, 1, 0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      int len;
      len = int'($urandom_range(1, 8));
      fill_rand(len);
      do_frame(len, int'($urandom_range(0, 255)), 2, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
    end

    // Longest frame.
    fill_rand(255);
    do_frame(255, 255, 0, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/complex_result_accumulator.md
Name: complex_result_accumulator

Overview:
- Downstream consumer of the complex multiplier's result handshake (res_val/res_ready).
- Accumulates a programmable number of consecutive complex products into a signed complex sum, such as a dot product or correlation tap sum.
- Presents the sum on its own valid/ready output port.
- Leaves the multiplier's control logic unchanged; this block drives only res_ready back to it.

Parameters:
- DATA_W, 17, width of each signed two's-complement product part (re, im) from the multiplier.
- GUARD_W, 8, extra accumulator bits; ACC_W = DATA_W + GUARD_W.
- CNT_W, 8, width of the frame length and product counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- sw_rst  in  1  reset, synchronous, active-high; the only reset.
- res_val  in  1  product valid from the multiplier.
- res_ready  out  1  block can accept a product this cycle.
- res_re  in  DATA_W  signed real part of the product.
- res_im  in  DATA_W  signed imaginary part of the product.
- frame_len  in  CNT_W  products per sum; sampled only on the first accepted product of a frame.
- acc_val  out  1  accumulated sum valid.
- acc_ready  in  1  consumer accepts the sum.
- acc_re  out  ACC_W  signed real sum.
- acc_im  out  ACC_W  signed imaginary sum.
- acc_cnt  out  CNT_W  number of products in the presented sum.
- acc_ovf  out  1  sticky: signed overflow occurred during this frame.

Behaviour:
- Single clock domain. One reset only: sw_rst, synchronous, active-high.
- Reset, with sw_rst high at a rising edge:
  - state = IDLE.
  - acc_re, acc_im, acc_cnt, internal counter, latched length and acc_ovf all cleared to 0.
  - acc_val = 0, res_ready = 1.
  - Reset wins over any simultaneous handshake; an in-progress frame is discarded with no output.
- Transfer rules:
  - A product transfers on a cycle with res_val & res_ready.
  - A sum transfers on a cycle with acc_val & acc_ready.
- res_ready is a registered-state decode: 1 in IDLE and ACCUM, 0 in DONE. It has no combinational path from acc_ready.
- Arithmetic:
  - Products are sign-extended to ACC_W and added with two's-complement wrap.
  - Overflow on an add is detected when both operands have the same sign and the result sign differs. It is checked separately on the re and im paths and ORed into acc_ovf.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - Accumulators hold 0.
  - On a product transfer: acc_re/acc_im load the sign-extended product, cnt = 1, and len latches frame_len.
  - A latched length of 0 is treated as 1.
  - If len == 1, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - On each transfer: add the product, cnt += 1.
  - When the new cnt == len, go to DONE.
  - No transfer means hold all values; the wait for res_val is unbounded.
- DONE:
  - acc_val = 1; acc_re, acc_im, acc_cnt (= len) and acc_ovf are held stable.
  - On acc_ready: clear the accumulators, cnt and acc_ovf, then go to IDLE.
  - The next product can be accepted from the cycle after the sum transfer.
- Latency: acc_val rises on the clock edge that captures the last product of the frame, so it is visible in the following cycle. This allows one frame every len+1 cycles when both sides stream.
- Outputs are registered, with no combinational input-to-output paths.
- The counter saturates at the frame length and never wraps. len = 255 is supported at CNT_W = 8.
- acc_ready outside DONE is ignored.
- Changes to frame_len mid-frame are ignored.
- acc_val never drops without a transfer or reset.

Test Plan:
- Reset behaviour: assert sw_rst 2 cycles during ACCUM with cnt = 3 -> next cycle acc_val = 0, res_ready = 1, acc_re = acc_im = 0, acc_ovf = 0; no sum is ever presented for the partial frame.
- Basic frame: frame_len = 3; products (5,-2), (-7,4), (100,1) streamed back-to-back; acc_ready = 1 -> acc_val for exactly 1 cycle, acc_re = 98, acc_im = 3, acc_cnt = 3, res_ready = 0 during that cycle.
- Backpressure: frame_len = 1, product (-65536,65535), acc_ready held 0 for 5 cycles -> acc_val and outputs stable across all 5, res_ready = 0; release -> transfer, then IDLE accepts the next product one cycle later.
- Length edge cases: frame_len = 0 -> behaves as 1.
- Mid-frame length change: frame_len changed from 4 to 2 after the first transfer -> the sum still covers 4 products.
- Overflow: GUARD_W = 0 (ACC_W = 17), frame_len = 2, products (65535,0) twice -> acc_re = -2 (wrapped), acc_ovf = 1; the next frame with (1,1) -> acc_ovf = 0.
- Gapped input: frame_len = 4 with res_val gaps of random 0-3 cycles between products (1,1) -> acc_re = acc_im = 4, acc_cnt = 4, no extra or missing accepts (scoreboard counts res_val & res_ready).
